buzzer_scheduler: RTL and testbench

- Shares the single piezo buzzer among several event sources: mic echo, hunger alarm, sleep alarm and game/UI click.
- Latches requests, grants the buzzer to one requester at a time by fixed priority, and plays that requester's beep pattern as a square-wave tone.
- Sits between the unit-control event logic and the top-level buzzer pin, replacing direct drive of the pin by individual blocks.

---
 rtl/buzzer_scheduler.sv | 142 ++++++++++++++
 tb/tb_buzzer_scheduler.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/buzzer_scheduler.sv
// Shares one piezo buzzer among several event sources: latches rising-edge requests,
// grants by fixed priority (index 0 highest) and plays i+1 beeps for requester i.
module buzzer_scheduler #(
    parameter int N_REQ     = 4,
    parameter int TONE_HALF = 25,
    parameter int ON_CYC    = 500,
    parameter int OFF_CYC   = 250,
    parameter int GAP_CYC   = 300
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic             mute,
    output logic             buzzer,
    output logic [N_REQ-1:0] grant,
    output logic             busy,
    output logic             done
);

    localparam int MAX_OO = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
    localparam int MAX_GT = (GAP_CYC > TONE_HALF) ? GAP_CYC : TONE_HALF;
    localparam int MAXC   = (MAX_OO > MAX_GT) ? MAX_OO : MAX_GT;
    localparam int CW     = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam int SW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW     = $clog2(N_REQ + 1);

    localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
    localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYC - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] TH_LAST  = CW'(TONE_HALF - 1);

    typedef enum logic [1:0] {IDLE, ON, OFF, GAP} state_t;

    state_t           state, state_nx;
    logic [N_REQ-1:0] pending, pending_nx, req_prev, grant_nx, clr, rise;
    logic [CW-1:0]    phase, phase_nx, tcnt, tcnt_nx;
    logic [BW-1:0]    beeps, beeps_nx;
    logic             tone, tone_nx, done_nx;
    logic [SW-1:0]    sel;

    // Lowest set index wins: scan downward so the last hit is the smallest index.
    always_comb begin
        sel = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (pending[i]) sel = SW'(i);
        end
    end

    assign rise = req & ~req_prev;
    assign busy = (state != IDLE);

    always_comb begin
        state_nx = state;
        grant_nx = grant;
        phase_nx = phase;
        tcnt_nx  = tcnt;
        beeps_nx = beeps;
        tone_nx  = tone;
        done_nx  = 1'b0;
        clr      = '0;
        case (state)
            IDLE: begin
                if (|pending) begin
                    state_nx = ON;
                    grant_nx = N_REQ'(1) << sel;
                    clr      = N_REQ'(1) << sel;
                    beeps_nx = BW'(sel) + BW'(1);
                    phase_nx = '0;
                    tcnt_nx  = '0;
                    tone_nx  = 1'b1;
                end
            end
            ON: begin
                if (phase == ON_LAST) begin
                    phase_nx = '0;
                    tcnt_nx  = '0;
                    tone_nx  = 1'b0;
                    beeps_nx = beeps - BW'(1);
                    state_nx = (beeps > BW'(1)) ? OFF : GAP;
                end else begin
                    phase_nx = phase + CW'(1);
                    if (tcnt == TH_LAST) begin
                        tcnt_nx = '0;
                        tone_nx = ~tone;
                    end else begin
                        tcnt_nx = tcnt + CW'(1);
                    end
                end
            end
            OFF: begin
                if (phase == OFF_LAST) begin
                    state_nx = ON;
                    phase_nx = '0;
                    tcnt_nx  = '0;
                    tone_nx  = 1'b1;
                end else begin
                    phase_nx = phase + CW'(1);
                end
            end
            GAP: begin
                if (phase == GAP_LAST) begin
                    state_nx = IDLE;
                    phase_nx = '0;
                    grant_nx = '0;
                    done_nx  = 1'b1;
                end else begin
                    phase_nx = phase + CW'(1);
                end
            end
            default: state_nx = IDLE;
        endcase
        // A new edge from the requester being granted this cycle survives the clear.
        pending_nx = (pending & ~clr) | rise;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pending  <= '0;
            req_prev <= '0;
            phase    <= '0;
            tcnt     <= '0;
            beeps    <= '0;
            tone     <= 1'b0;
            grant    <= '0;
            done     <= 1'b0;
            buzzer   <= 1'b0;
        end else begin
            state    <= state_nx;
            pending  <= pending_nx;
            req_prev <= req;
            phase    <= phase_nx;
            tcnt     <= tcnt_nx;
            beeps    <= beeps_nx;
            tone     <= tone_nx;
            grant    <= grant_nx;
            done     <= done_nx;
            buzzer   <= tone_nx & ~mute;
        end
    end

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Directed bench for buzzer_scheduler with TONE_HALF=2, ON_CYC=8, OFF_CYC=4, GAP_CYC=6.
module tb_buzzer_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic       mute;
    logic       buzzer;
    logic [3:0] grant;
    logic       busy;
    logic       done;

    int n_cmp = 0;
    int n_err = 0;
    int inj_at = -10;
    logic [3:0] inj_val = 4'b0000;

    buzzer_scheduler #(
        .N_REQ(4), .TONE_HALF(2), .ON_CYC(8), .OFF_CYC(4), .GAP_CYC(6)
    ) dut (
        .clk(clk), .rst(rst), .req(req), .mute(mute),
        .buzzer(buzzer), .grant(grant), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic eb, input logic [3:0] eg,
                           input logic ebusy, input logic ed);
        chk($sformatf("%s.buzzer", tag), 32'(buzzer), 32'(eb));
        chk($sformatf("%s.grant", tag), 32'(grant), 32'(eg));
        chk($sformatf("%s.busy", tag), 32'(busy), 32'(ebusy));
        chk($sformatf("%s.done", tag), 32'(done), 32'(ed));
    endtask

    // Plays out one full pattern for requester i, starting at the grant edge and ending
    // on the done cycle. Optionally raises inj_val on req after pattern cycle inj_at.
    task automatic expect_pattern(input string tag, input int i, input bit muted);
        int t;
        logic [3:0] g;
        logic eb;
        t = 0;
        g = 4'(1 << i);
        for (int b = 0; b <= i; b++) begin
            for (int c = 0; c < 8; c++) begin
                step();
                t++;
                eb = muted ? 1'b0 : ((c % 4) < 2);
                chk_out($sformatf("%s on b%0d t%0d", tag, b, t), eb, g, 1'b1, 1'b0);
                if (t == inj_at) req = inj_val;
                else if (t == inj_at + 1) req = 4'b0000;
            end
            if (b < i) begin
                for (int c = 0; c < 4; c++) begin
                    step();
                    t++;
                    chk_out($sformatf("%s off b%0d t%0d", tag, b, t), 1'b0, g, 1'b1, 1'b0);
                    if (t == inj_at) req = inj_val;
                    else if (t == inj_at + 1) req = 4'b0000;
                end
            end
        end
        for (int c = 0; c < 6; c++) begin
            step();
            t++;
            chk_out($sformatf("%s gap t%0d", tag, t), 1'b0, g, 1'b1, 1'b0);
        end
        step();
        chk_out($sformatf("%s done", tag), 1'b0, 4'b0000, 1'b0, 1'b1);
    endtask

    initial begin
        rst  = 1'b0;
        req  = 4'b0000;
        mute = 1'b0;

        // Scenario 1: reset held while req toggles, then release with req low.
        for (int i = 0; i < 6; i++) begin
            req = 4'(i * 5);
            step();
            chk_out($sformatf("s1 rst c%0d", i), 1'b0, 4'b0000, 1'b0, 1'b0);
        end
        req = 4'b0000;
        step();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk_out($sformatf("s1 idle c%0d", i), 1'b0, 4'b0000, 1'b0, 1'b0);
        end

        // Scenario 2: single req[0].
        req = 4'b0001;
        step();
        chk_out("s2 edge", 1'b0, 4'b0000, 1'b0, 1'b0);
        req = 4'b0000;
        expect_pattern("s2", 0, 1'b0);
        step();
        chk_out("s2 after", 1'b0, 4'b0000, 1'b0, 1'b0);

        // Scenario 3: req[2] alone, three beeps.
        req = 4'b0100;
        step();
        chk_out("s3 edge", 1'b0, 4'b0000, 1'b0, 1'b0);
        req = 4'b0000;
        expect_pattern("s3", 2, 1'b0);
        step();
        chk_out("s3 after", 1'b0, 4'b0000, 1'b0, 1'b0);

        // Scenario 4: req[3] and req[1] together; index 1 served first.
        req = 4'b1010;
        step();
        chk_out("s4 edge", 1'b0, 4'b0000, 1'b0, 1'b0);
        req = 4'b0000;
        expect_pattern("s4a", 1, 1'b0);
        expect_pattern("s4b", 3, 1'b0);
        step();
        chk_out("s4 after", 1'b0, 4'b0000, 1'b0, 1'b0);

        // Scenario 5: req[0] and a repeat req[2] arrive during requester 2's second beep.
        req = 4'b0100;
        step();
        req = 4'b0000;
        inj_at  = 15;
        inj_val = 4'b0101;
        expect_pattern("s5a", 2, 1'b0);
        inj_at = -10;
        expect_pattern("s5b", 0, 1'b0);
        expect_pattern("s5c", 2, 1'b0);
        step();
        chk_out("s5 after", 1'b0, 4'b0000, 1'b0, 1'b0);

        // Scenario 6a: muted pattern keeps identical timing.
        mute = 1'b1;
        req  = 4'b0001;
        step();
        chk_out("s6a edge", 1'b0, 4'b0000, 1'b0, 1'b0);
        req = 4'b0000;
        expect_pattern("s6a", 0, 1'b1);
        mute = 1'b0;
        step();

        // Scenario 6b: reset mid-ON aborts and discards the pending req[3].
        req = 4'b1001;
        step();
        req = 4'b0000;
        step();
        chk_out("s6b grant", 1'b1, 4'b0001, 1'b1, 1'b0);
        step();
        step();
        chk_out("s6b on", 1'b0, 4'b0001, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        chk_out("s6b async", 1'b0, 4'b0000, 1'b0, 1'b0);
        step();
        step();
        rst = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_out($sformatf("s6b idle c%0d", i), 1'b0, 4'b0000, 1'b0, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
